// File: rtl/mayur_seq_divider_pkg.sv
// mayur_seq_divider_pkg: shared widths and FSM state encoding for the sequential divider
//   DIVIDEND_W_DEF : default dividend/quotient width (a 3x3 product width)
//   DIVISOR_W_DEF  : default divisor/remainder width
//   state_t        : IDLE=0, CALC=1, DONE=2
package mayur_seq_divider_pkg;
    localparam int DIVIDEND_W_DEF = 6;
    localparam int DIVISOR_W_DEF = 3;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mayur_seq_divider_if.sv
// mayur_seq_divider_if: start/busy/done handshake and operand/result bus of the divider
//   start, dividend, divisor                          : requester -> divider
//   busy, done, quotient, remainder, div_by_zero      : divider -> requester
//   modport master : requester side; modport slave : divider side
interface mayur_seq_divider_if
    import mayur_seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W = DIVISOR_W_DEF
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mayur_seq_divider_step.sv
// mayur_full_adder / mayur_div_step: one restoring-division step built from full-adder cells
//   mayur_full_adder : a, b, ci -> s, co
//   mayur_div_step   : t (partial remainder with next dividend bit), divisor
//                      -> rem (restored or reduced remainder), qbit (t >= divisor)
module mayur_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module mayur_div_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W:0]   t,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem,
    output logic                 qbit
);
    logic [DIVISOR_W-1:0] diff;
    logic [DIVISOR_W:0]   c;
    assign c[0] = 1'b1;
    for (genvar i = 0; i < DIVISOR_W; i++) begin : g_fa
        mayur_full_adder u_fa (
            .a (t[i]),
            .b (~divisor[i]),
            .ci(c[i]),
            .s (diff[i]),
            .co(c[i+1])
        );
    end
    // Top cell subtracts an implicit 0 (inverted to 1); only its carry is needed,
    // since a kept difference is below divisor and fits in DIVISOR_W bits.
    assign qbit = t[DIVISOR_W] | c[DIVISOR_W];
    assign rem = qbit ? diff : t[DIVISOR_W-1:0];
endmodule

// File: rtl/mayur_seq_divider.sv
// mayur_seq_divider: restoring divider, one quotient bit per clock, start/busy/done handshake
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of mayur_seq_divider_if (start/operands in, busy/done/results out)
module mayur_seq_divider
    import mayur_seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input logic clk,
    input logic rst,
    mayur_seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    state_t                state, state_nxt;
    logic                  accept, zero_div, qbit;
    logic [DIVISOR_W-1:0]  dvs, r, r_nxt, rem_q;
    logic [DIVIDEND_W-1:0] q, q_nxt, quo_q;
    logic [DIVISOR_W:0]    t;
    logic [CNT_W-1:0]      cnt;
    logic                  dbz_q;
    assign zero_div = bus.divisor == '0;
    // start is only heard between operations, so an in-flight division is never disturbed
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign t = {r, q[DIVIDEND_W-1]};
    assign q_nxt = {q[DIVIDEND_W-2:0], qbit};
    mayur_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .t      (t),
        .divisor(dvs),
        .rem    (r_nxt),
        .qbit   (qbit)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == CALC) state_nxt = cnt == '0 ? DONE : CALC;
        else if (accept) state_nxt = zero_div ? DONE : CALC;
        else if (state == DONE) state_nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvs <= '0;
            q <= '0;
            r <= '0;
            cnt <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            dvs <= bus.divisor;
            q <= bus.dividend;
            r <= '0;
            cnt <= CNT_W'(DIVIDEND_W - 1);
            dbz_q <= zero_div;
            if (zero_div) begin
                quo_q <= '1;
                rem_q <= '0;
            end
        end else if (state == CALC) begin
            q <= q_nxt;
            r <= r_nxt;
            cnt <= cnt - 1'b1;
            // results are published only on the final step, never mid-calculation
            if (cnt == '0) begin
                quo_q <= q_nxt;
                rem_q <= r_nxt;
            end
        end
    end
    assign bus.busy = state == CALC;
    assign bus.done = state == DONE;
    assign bus.quotient = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mayur_seq_divider.sv
// tb_mayur_seq_divider: directed table, handshake corner sequences and randomized/exhaustive model checks
module tb_mayur_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    mayur_seq_divider_if #(.DIVIDEND_W(6), .DIVISOR_W(3)) bus ();
    mayur_seq_divider #(.DIVIDEND_W(6), .DIVISOR_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [2:0] b;
        int q;
        int r;
        int dz;
        int edges;
        int busy;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_op(input logic [5:0] a, input logic [2:0] b, output int edges,
                          output int busy_n, output logic [5:0] q, output logic [2:0] r,
                          output logic dz);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 6'($urandom);
        bus.divisor = 3'($urandom);
        edges = 1;
        busy_n = 0;
        while (!bus.done && edges < 20) begin
            busy_n += int'(bus.busy);
            @(negedge clk);
            edges++;
        end
        q = bus.quotient;
        r = bus.remainder;
        dz = bus.div_by_zero;
    endtask

    // reference model: plain integer division with the divide-by-zero convention
    function automatic int ref_q(input int a, input int b);
        return b == 0 ? 63 : a / b;
    endfunction
    function automatic int ref_r(input int a, input int b);
        return b == 0 ? 0 : a % b;
    endfunction

    initial begin
        vec_t tv[6];
        int edges, busy_n, dones, qc, rc;
        logic [5:0] q;
        logic [2:0] r;
        logic dz;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        tv[0] = '{6'd45, 3'd6, 7, 3, 0, 7, 6};
        tv[1] = '{6'd63, 3'd7, 9, 0, 0, 7, 6};
        tv[2] = '{6'd5, 3'd7, 0, 5, 0, 7, 6};
        tv[3] = '{6'd20, 3'd0, 63, 0, 1, 1, 0};
        tv[4] = '{6'd9, 3'd2, 4, 1, 0, 7, 6};
        tv[5] = '{6'd50, 3'd5, 10, 0, 0, 7, 6};
        repeat (2) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset quotient", int'(bus.quotient), 0);
        chk("reset remainder", int'(bus.remainder), 0);
        chk("reset dbz", int'(bus.div_by_zero), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].a, tv[i].b, edges, busy_n, q, r, dz);
            chk($sformatf("tv%0d quotient", i), int'(q), tv[i].q);
            chk($sformatf("tv%0d remainder", i), int'(r), tv[i].r);
            chk($sformatf("tv%0d dbz", i), int'(dz), tv[i].dz);
            chk($sformatf("tv%0d done latency", i), edges, tv[i].edges);
            chk($sformatf("tv%0d busy cycles", i), busy_n, tv[i].busy);
            @(negedge clk);
            chk($sformatf("tv%0d done pulse width", i), int'(bus.done), 0);
            chk($sformatf("tv%0d quotient held", i), int'(bus.quotient), tv[i].q);
        end

        // start and operand changes during CALC are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 6'd45;
        bus.divisor = 3'd6;
        dones = 0;
        qc = -1;
        rc = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.start = c == 3;
            if (c == 3) begin
                bus.dividend = 6'd10;
                bus.divisor = 3'd3;
            end
            if (bus.done) begin
                dones++;
                qc = int'(bus.quotient);
                rc = int'(bus.remainder);
            end
        end
        chk("ignore start done count", dones, 1);
        chk("ignore start quotient", qc, 7);
        chk("ignore start remainder", rc, 3);

        // asynchronous reset mid-calculation aborts without a done
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 6'd63;
        bus.divisor = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", int'(bus.busy), 0);
        chk("async rst quotient", int'(bus.quotient), 0);
        chk("async rst remainder", int'(bus.remainder), 0);
        chk("async rst dbz", int'(bus.div_by_zero), 0);
        chk("async rst done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("aborted op done count", dones, 0);
        run_op(6'd9, 3'd2, edges, busy_n, q, r, dz);
        chk("after rst quotient", int'(q), 4);
        chk("after rst remainder", int'(r), 1);

        // start held in DONE: next operation accepted with no idle cycle
        run_op(6'd45, 3'd6, edges, busy_n, q, r, dz);
        bus.start = 1'b1;
        bus.dividend = 6'd50;
        bus.divisor = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b busy immediately", int'(bus.busy), 1);
        edges = 1;
        while (!bus.done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("b2b latency", edges, 7);
        chk("b2b quotient", int'(bus.quotient), 10);
        chk("b2b remainder", int'(bus.remainder), 0);

        // randomized operations against the model
        repeat (40) begin
            logic [5:0] a;
            logic [2:0] b;
            a = 6'($urandom);
            b = 3'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(a, b, edges, busy_n, q, r, dz);
            chk($sformatf("rand %0d/%0d quotient", a, b), int'(q), ref_q(int'(a), int'(b)));
            chk($sformatf("rand %0d/%0d remainder", a, b), int'(r), ref_r(int'(a), int'(b)));
            chk($sformatf("rand %0d/%0d dbz", a, b), int'(dz), int'(b == 0));
        end

        // exhaustive sweep of all operand pairs
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_op(6'(a), 3'(b), edges, busy_n, q, r, dz);
                if (b == 0) begin
                    chk($sformatf("sweep %0d/0 dbz result", a), int'({q, r, dz}), int'({6'd63, 3'd0, 1'b1}));
                end else begin
                    chk($sformatf("sweep %0d/%0d invariant", a, b), int'(q) * b + int'(r), a);
                    chk($sformatf("sweep %0d/%0d rem bound", a, b), int'(int'(r) < b), 1);
                    chk($sformatf("sweep %0d/%0d quotient", a, b), int'(q), ref_q(a, b));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
